ram_mp: RTL

RAM_MP -- requirements
Module: ram_mp

---
 rtl/ram_mp_pkg.sv | 15 +
 rtl/ram_mp_clear.sv | 68 ++++++
 rtl/ram_mp.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg -- shared definitions for the multi-port RAM.
//   clr_state_e : clear sequencer states (IDLE, CLEAR)
//   lane_count  : number of byte lanes in a data word
package ram_mp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int lane_count(input int word_bits, input int lane_bits);
        return word_bits / lane_bits;
    endfunction

endpackage

// File: rtl/ram_mp_clear.sv
// ram_mp_clear -- clear sequencer for ram_mp.
// Walks every address once, ascending from 0, and returns to IDLE on the wrap
// from the last address. Reset forces a fresh walk from address 0.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_clear     start pulse (only honoured in IDLE)
//   o_busy      high while the walk runs
//   o_clr_addr  address being cleared this cycle
//   o_clr_we    write strobe for the clear word
module ram_mp_clear
    import ram_mp_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    output logic                 o_busy,
    output logic [ADDR_BITS-1:0] o_clr_addr,
    output logic                 o_clr_we
);

    clr_state_e           r_state;
    clr_state_e           w_state_d;
    logic [ADDR_BITS-1:0] r_cnt;
    logic [ADDR_BITS-1:0] w_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_clear) begin
                    w_state_d = CLEAR;
                    w_cnt_d   = '0;
                end
            end
            CLEAR: begin
                // Counter wraps to 0 on the last address, ready for the next run.
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == {ADDR_BITS{1'b1}}) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy     = (r_state == CLEAR);
        o_clr_we   = (r_state == CLEAR);
        o_clr_addr = r_cnt;
    end

endmodule

// File: rtl/ram_mp.sv
// ram_mp -- multi-port RAM with byte-lane writes, selectable read latency and
// read-during-write behaviour, and a hardware clear sequence.
// Optional feature: define RAM_MP_PARITY_EN to store one even-parity bit per
// lane and expose out_parity_err.
// Ports:
//   in_clk          clock (rising edge)
//   in_rst          asynchronous active-low reset
//   in_read_ena     per-port read request
//   in_write_ena    per-port write request
//   in_lane_ena     per-port byte-lane write mask
//   in_addr         per-port address
//   in_data         per-port write data
//   in_clear        pulse that starts a full clear
//   out_data        per-port read data (holds while out_valid is low)
//   out_valid       per-port read data qualifier
//   out_parity_err  per-port parity error, qualified by out_valid (macro only)
//   out_busy        high while the clear sequence runs
module ram_mp
    import ram_mp_pkg::*;
#(
    parameter int unsigned          NUM_PORTS    = 2,
    parameter int unsigned          ADDR_BITS    = 8,
    parameter int unsigned          WORD_BITS    = 8,
    parameter int unsigned          LANE_BITS    = 8,
    parameter int unsigned          READ_LATENCY = 1,
    parameter int unsigned          WRITE_FIRST  = 0,
    parameter logic [WORD_BITS-1:0] CLEAR_VALUE  = '0
) (
    input  logic                                                      in_clk,
    input  logic                                                      in_rst,
    input  logic [NUM_PORTS-1:0]                                      in_read_ena,
    input  logic [NUM_PORTS-1:0]                                      in_write_ena,
    input  logic [NUM_PORTS-1:0][lane_count(WORD_BITS, LANE_BITS)-1:0] in_lane_ena,
    input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]                       in_addr,
    input  logic [NUM_PORTS-1:0][WORD_BITS-1:0]                       in_data,
    input  logic                                                      in_clear,
    output logic [NUM_PORTS-1:0][WORD_BITS-1:0]                       out_data,
    output logic [NUM_PORTS-1:0]                                      out_valid,
`ifdef RAM_MP_PARITY_EN
    output logic [NUM_PORTS-1:0]                                      out_parity_err,
`endif
    output logic                                                      out_busy
);

    localparam int LANES = lane_count(WORD_BITS, LANE_BITS);
    localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef RAM_MP_PARITY_EN
    localparam int PAR_BITS = LANES;
`else
    localparam int PAR_BITS = 0;
`endif
    // Stored entry: data in the low bits, lane parity (if any) above it.
    localparam int ENTRY_BITS = WORD_BITS + PAR_BITS;

    typedef logic [ENTRY_BITS-1:0] entry_t;

    function automatic entry_t make_entry(input logic [WORD_BITS-1:0] word);
        entry_t entry;
        entry                = '0;
        entry[WORD_BITS-1:0] = word;
`ifdef RAM_MP_PARITY_EN
        for (int l = 0; l < LANES; l++) begin
            entry[WORD_BITS + l] = ^word[l*LANE_BITS +: LANE_BITS];
        end
`endif
        return entry;
    endfunction

    function automatic logic [WORD_BITS-1:0] merge_lanes(
        input logic [WORD_BITS-1:0] old_word,
        input logic [WORD_BITS-1:0] new_word,
        input logic [LANES-1:0]     lanes
    );
        logic [WORD_BITS-1:0] merged;
        merged = old_word;
        for (int l = 0; l < LANES; l++) begin
            if (lanes[l]) begin
                merged[l*LANE_BITS +: LANE_BITS] = new_word[l*LANE_BITS +: LANE_BITS];
            end
        end
        return merged;
    endfunction

    localparam entry_t CLEAR_ENTRY = make_entry(CLEAR_VALUE);

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    logic                 w_busy;
    logic [ADDR_BITS-1:0] w_clr_addr;
    logic                 w_clr_we;

    ram_mp_clear #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clear (
        .i_clk      (in_clk),
        .i_rst_n    (in_rst),
        .i_clear    (in_clear),
        .o_busy     (w_busy),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we)
    );

    // Port accesses are dropped entirely while the clear runs.
    logic [NUM_PORTS-1:0] w_rd_acc;
    logic [NUM_PORTS-1:0] w_wr_acc;

    always_comb begin
        w_rd_acc = in_read_ena & {NUM_PORTS{~w_busy}};
        w_wr_acc = in_write_ena & {NUM_PORTS{~w_busy}};
    end

    // ------------------------------------------------------------------------
    // Storage and write/read merge
    // ------------------------------------------------------------------------
    entry_t r_mem [DEPTH];

    logic   [NUM_PORTS-1:0][WORD_BITS-1:0] w_wr_word;
    entry_t [NUM_PORTS-1:0]                w_rd_entry;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            // Every port writing an address computes the same fully merged word,
            // so same-address writes agree. The ascending scan lets the highest
            // enabled port own each lane.
            w_wr_word[p] = r_mem[in_addr[p]][WORD_BITS-1:0];
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (w_wr_acc[q] && (in_addr[q] == in_addr[p])) begin
                    w_wr_word[p] = merge_lanes(w_wr_word[p], in_data[q], in_lane_ena[q]);
                end
            end
            // Write-first forwards only this port's own write; other ports' writes
            // in the same cycle stay invisible to this read.
            w_rd_entry[p] = r_mem[in_addr[p]];
            if ((WRITE_FIRST != 0) && w_wr_acc[p]) begin
                w_rd_entry[p] = make_entry(merge_lanes(r_mem[in_addr[p]][WORD_BITS-1:0],
                                                       in_data[p], in_lane_ena[p]));
            end
        end
    end

    // Contents are deliberately not reset; the clear sequence initialises them.
    always_ff @(posedge in_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_ENTRY;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_wr_acc[p]) begin
                    r_mem[in_addr[p]] <= make_entry(w_wr_word[p]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------------
    entry_t [NUM_PORTS-1:0] r_out_entry;
    logic   [NUM_PORTS-1:0] r_out_valid;

    if (READ_LATENCY == 2) begin : g_lat2
        entry_t [NUM_PORTS-1:0] r_s1_entry;
        logic   [NUM_PORTS-1:0] r_s1_valid;

        // The second stage is not gated by busy so a read in flight when a
        // clear starts still delivers its pre-clear data.
        always_ff @(posedge in_clk or negedge in_rst) begin
            if (!in_rst) begin
                r_s1_entry  <= '0;
                r_s1_valid  <= '0;
                r_out_entry <= '0;
                r_out_valid <= '0;
            end else begin
                r_s1_valid  <= w_rd_acc;
                r_out_valid <= r_s1_valid;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (w_rd_acc[p]) begin
                        r_s1_entry[p] <= w_rd_entry[p];
                    end
                    if (r_s1_valid[p]) begin
                        r_out_entry[p] <= r_s1_entry[p];
                    end
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge in_clk or negedge in_rst) begin
            if (!in_rst) begin
                r_out_entry <= '0;
                r_out_valid <= '0;
            end else begin
                r_out_valid <= w_rd_acc;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (w_rd_acc[p]) begin
                        r_out_entry[p] <= w_rd_entry[p];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            out_data[p] = r_out_entry[p][WORD_BITS-1:0];
        end
        out_valid = r_out_valid;
        out_busy  = w_busy;
    end

`ifdef RAM_MP_PARITY_EN
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            out_parity_err[p] = r_out_valid[p] &&
                (r_out_entry[p] != make_entry(r_out_entry[p][WORD_BITS-1:0]));
        end
    end
`endif

endmodule
